// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the MEM-stage memory access controller.
package mem_ctrl_pkg;

    localparam logic [1:0] MEM_IDLE = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] MEM_DONE = 2'd2;

    localparam int unsigned TIMEOUT_DEFAULT = 32;

    localparam logic [15:0] ABORT_DATA = 16'hFFFF;

endpackage

// File: rtl/mem_timeout_cnt.sv
// 8-bit WAIT-cycle counter; expired flags the last cycle allowed before abort.
module mem_timeout_cnt
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign expired = (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage memory access controller: req/ack handshake with a multi-cycle data memory.
// Optional misaligned-access rejection is compiled in with `define ALIGN_CHECK_EN.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_mem_rd,
    input  logic              in_mem_wr,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [ADDR_W-1:0] in_wr_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [ADDR_W-1:0] mem_rdata,
    output logic              stall_n,
    output logic [ADDR_W-1:0] out_mem_out,
    output logic              err
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       req_any;
    logic       req_bad;
    logic       start;
    logic       expired;

    assign req_any = in_mem_rd | in_mem_wr;

`ifdef ALIGN_CHECK_EN
    assign req_bad = (in_mem_rd & in_mem_wr) | (req_any & in_addr[0]);
`else
    assign req_bad = in_mem_rd & in_mem_wr;
`endif

    // Rejected requests let the instruction pass without touching memory.
    assign start = (state == MEM_IDLE) & req_any & ~req_bad;

    always_comb begin
        stall_n   = 1'b1;
        state_nxt = MEM_IDLE;
        case (state)
            MEM_IDLE: begin
                stall_n   = ~start;
                state_nxt = start ? MEM_WAIT : MEM_IDLE;
            end
            MEM_WAIT: begin
                stall_n   = 1'b0;
                state_nxt = (mem_ack | expired) ? MEM_DONE : MEM_WAIT;
            end
            MEM_DONE: begin
                stall_n   = 1'b1;
                state_nxt = MEM_IDLE;
            end
            default: begin
                stall_n   = 1'b1;
                state_nxt = MEM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= MEM_IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            out_mem_out <= '0;
            err         <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                MEM_IDLE: begin
                    if (start) begin
                        mem_addr  <= in_addr;
                        mem_wdata <= in_wr_data;
                        mem_we    <= in_mem_wr;
                        mem_req   <= 1'b1;
                    end
                    if (req_bad | mem_ack) begin
                        err <= 1'b1;
                    end
                end
                MEM_WAIT: begin
                    // An ack on the final allowed cycle still wins over the abort.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            out_mem_out <= mem_rdata;
                        end
                    end else if (expired) begin
                        mem_req     <= 1'b0;
                        err         <= 1'b1;
                        out_mem_out <= ADDR_W'(ABORT_DATA);
                    end
                end
                MEM_DONE: begin
                    if (mem_ack) begin
                        err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    mem_timeout_cnt #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (state != MEM_WAIT),
        .en     (state == MEM_WAIT),
        .expired(expired)
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: vector table, scoreboard and hand-written corner sequences.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_mem_rd, in_mem_wr, mem_ack;
    logic [15:0] in_addr, in_wr_data, mem_rdata;
    logic        mem_req, mem_we, stall_n, err;
    logic [15:0] mem_addr, mem_wdata, out_mem_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .ADDR_W (16),
        .TIMEOUT(32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_mem_rd  (in_mem_rd),
        .in_mem_wr  (in_mem_wr),
        .in_addr    (in_addr),
        .in_wr_data (in_wr_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .stall_n    (stall_n),
        .out_mem_out(out_mem_out),
        .err        (err)
    );

    // delay: WAIT cycle (1-based) in which ack is driven, 0 = never.
    // exp_low: stall_n low cycles, 0 = request rejected in IDLE.
    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          delay;
        int          exp_low;
        logic [15:0] exp_out;
        logic        exp_err;
    } vec_t;

    vec_t sb[$];
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run_txn(input vec_t v);
        vec_t e;
        int   low  = 0;
        int   reqc = 0;
        bit   done = 0;
        sb.push_back(v);
        @(posedge clk); #1;
        in_mem_rd  = v.rd;
        in_mem_wr  = v.wr;
        in_addr    = v.addr;
        in_wr_data = v.wdata;
        mem_ack    = 1'b0;
        #1;
        if (!stall_n) low++;
        check("stall_n_issue", 32'(stall_n), 32'(v.exp_low == 0));
        for (int k = 1; k <= 300 && !done; k++) begin
            @(posedge clk); #1;
            if (v.exp_low == 0) begin
                in_mem_rd = 1'b0;
                in_mem_wr = 1'b0;
            end
            mem_ack   = (k == v.delay);
            mem_rdata = (k == v.delay) ? v.rdata : 16'hDEAD;
            #1;
            if (stall_n) begin
                done = 1;
            end else begin
                low++;
                if (mem_req) reqc++;
                check("wait_mem_req", 32'(mem_req), 32'd1);
                check("wait_mem_we", 32'(mem_we), 32'(v.wr));
                check("wait_mem_addr", 32'(mem_addr), 32'(v.addr));
                check("wait_mem_wdata", 32'(mem_wdata), 32'(v.wdata));
            end
        end
        if (!done) check("txn_bound_expired", 32'd0, 32'd1);
        e = sb.pop_front();
        check("done_out_mem_out", 32'(out_mem_out), 32'(e.exp_out));
        check("done_err", 32'(err), 32'(e.exp_err));
        check("done_mem_req", 32'(mem_req), 32'd0);
        check("stall_low_cycles", 32'(low), 32'(e.exp_low));
        check("req_high_cycles", 32'(reqc), 32'((e.exp_low == 0) ? 0 : e.exp_low - 1));
        in_mem_rd = 1'b0;
        in_mem_wr = 1'b0;
        mem_ack   = 1'b0;
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t t;
        vecs[0] = '{rd:1'b1, wr:1'b0, addr:16'h0040, wdata:16'h0000, rdata:16'hBEEF,
                    delay:1, exp_low:2, exp_out:16'hBEEF, exp_err:1'b0};
        vecs[1] = '{rd:1'b0, wr:1'b1, addr:16'h0102, wdata:16'h1234, rdata:16'h7777,
                    delay:5, exp_low:6, exp_out:16'hBEEF, exp_err:1'b0};
        vecs[2] = '{rd:1'b1, wr:1'b0, addr:16'h0200, wdata:16'h0000, rdata:16'h1357,
                    delay:2, exp_low:3, exp_out:16'h1357, exp_err:1'b0};
        vecs[3] = '{rd:1'b0, wr:1'b1, addr:16'h0300, wdata:16'hABCD, rdata:16'h9999,
                    delay:1, exp_low:2, exp_out:16'h1357, exp_err:1'b0};
`ifdef ALIGN_CHECK_EN
        vecs[4] = '{rd:1'b1, wr:1'b0, addr:16'h0041, wdata:16'h0000, rdata:16'h5A5A,
                    delay:0, exp_low:0, exp_out:16'h1357, exp_err:1'b1};
`else
        vecs[4] = '{rd:1'b1, wr:1'b0, addr:16'h0041, wdata:16'h0000, rdata:16'h5A5A,
                    delay:3, exp_low:4, exp_out:16'h5A5A, exp_err:1'b0};
`endif

        rst        = 1'b1;
        in_mem_rd  = 1'b0;
        in_mem_wr  = 1'b0;
        in_addr    = 16'h0000;
        in_wr_data = 16'h0000;
        mem_ack    = 1'b0;
        mem_rdata  = 16'h0000;
        #2;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_out_mem_out", 32'(out_mem_out), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_stall_n", 32'(stall_n), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_txn(vecs[i]);

        // Reset in the third WAIT cycle abandons the access.
        @(posedge clk); #1;
        in_mem_rd  = 1'b1;
        in_addr    = 16'h0AA0;
        in_wr_data = 16'h5555;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_mem_req", 32'(mem_req), 32'd1);
        rst       = 1'b1;
        in_mem_rd = 1'b0;
        #1;
        check("midrst_mem_req", 32'(mem_req), 32'd0);
        check("midrst_mem_we", 32'(mem_we), 32'd0);
        check("midrst_mem_addr", 32'(mem_addr), 32'd0);
        check("midrst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("midrst_out_mem_out", 32'(out_mem_out), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        check("midrst_stall_n", 32'(stall_n), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        t = '{rd:1'b1, wr:1'b0, addr:16'h0050, wdata:16'h0000, rdata:16'hC0DE,
              delay:2, exp_low:3, exp_out:16'hC0DE, exp_err:1'b0};
        run_txn(t);

        // No ack: abort after 32 WAIT cycles.
        t = '{rd:1'b1, wr:1'b0, addr:16'h0060, wdata:16'h0000, rdata:16'h0000,
              delay:0, exp_low:33, exp_out:16'hFFFF, exp_err:1'b1};
        run_txn(t);
        repeat (3) @(posedge clk);
        #2;
        check("err_sticky_idle", 32'(err), 32'd1);
        t = '{rd:1'b1, wr:1'b0, addr:16'h0064, wdata:16'h0000, rdata:16'h2468,
              delay:1, exp_low:2, exp_out:16'h2468, exp_err:1'b1};
        run_txn(t);

        pulse_rst();
        #2;
        check("err_cleared_by_rst", 32'(err), 32'd0);

        t = '{rd:1'b1, wr:1'b1, addr:16'h0070, wdata:16'h1111, rdata:16'h0000,
              delay:0, exp_low:0, exp_out:16'h0000, exp_err:1'b1};
        run_txn(t);

        pulse_rst();
        @(posedge clk); #1;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        #1;
        check("spurious_ack_err", 32'(err), 32'd1);
        check("spurious_ack_req", 32'(mem_req), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
